// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the decode-stage interlock scoreboard.
package hazard_scoreboard_pkg;

  localparam int SLOT_W    = 4;
  localparam int REG_IDX_W = 3;

  // One in-flight register write: valid flag plus destination index.
  typedef struct packed {
    logic                 wv;
    logic [REG_IDX_W-1:0] wr;
  } slot_t;

  localparam slot_t SLOT_CLR = '{wv: 1'b0, wr: '0};

endpackage

// File: rtl/dff.sv
// Generic register with asynchronous active-low clear.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d every rising edge; clear immediately when rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/hazard_slot_cmp.sv
// Compares one scoreboard slot against the decode-stage source operands.
module hazard_slot_cmp
  import hazard_scoreboard_pkg::*;
(
  input  slot_t                slot,
  input  logic                 rs_used,
  input  logic [REG_IDX_W-1:0] rs,
  input  logic                 rt_used,
  input  logic [REG_IDX_W-1:0] rt,
  output logic                 hit
);

  assign hit = slot.wv & ((rs_used & (rs == slot.wr)) | (rt_used & (rt == slot.wr)));

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage interlock: read-after-write stalls from a 3-deep write
// scoreboard, wrong-path squash on redirect, sticky halt and stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic                 id_rs_used,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic                 id_rt_used,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_reg_write,
  input  logic [REG_IDX_W-1:0] id_write_reg,
  input  logic                 id_halt,
  input  logic                 ex_redirect,
  output logic                 stall,
  output logic                 nop,
  output logic                 flush_fd,
  output logic                 halted,
  output logic [CNT_W-1:0]     stall_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  slot_t            x_d, x_q, m_q;
  logic             halted_d, halted_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             hit_x, hit_m, hit_w, haz;

  hazard_slot_cmp u_cmp_x (
    .slot(x_q), .rs_used(id_rs_used), .rs(id_rs),
    .rt_used(id_rt_used), .rt(id_rt), .hit(hit_x)
  );

  hazard_slot_cmp u_cmp_m (
    .slot(m_q), .rs_used(id_rs_used), .rs(id_rs),
    .rt_used(id_rt_used), .rt(id_rt), .hit(hit_m)
  );

  // The writeback slot only matters when the register file cannot forward
  // a same-cycle write, so it is only built in that configuration.
  if (!WB_BYPASS) begin : g_wb_cmp
    slot_t w_q;
    dff #(.W(SLOT_W)) u_w (.clk(clk), .rst_n(rst), .d(m_q), .q(w_q));
    hazard_slot_cmp u_cmp_w (
      .slot(w_q), .rs_used(id_rs_used), .rs(id_rs),
      .rt_used(id_rt_used), .rt(id_rt), .hit(hit_w)
    );
  end else begin : g_wb_bypass
    assign hit_w = 1'b0;
  end

  assign haz = id_valid & (hit_x | hit_m | hit_w);

  // Redirect wins over hazard: the decode instruction is wrong-path, so it
  // is squashed rather than held.
  assign stall       = (haz | halted_q) & ~ex_redirect;
  assign nop         = stall | ex_redirect | halted_q;
  assign flush_fd    = ex_redirect;
  assign halted      = halted_q;
  assign stall_count = cnt_q;

  // Next-state: only an instruction that actually issues enters X; stalls
  // and squashes push a bubble so the slots track the real pipe contents.
  always_comb begin
    x_d = SLOT_CLR;
    if (id_valid & ~nop & id_reg_write) begin
      x_d = '{wv: 1'b1, wr: id_write_reg};
    end
    halted_d = halted_q | (id_valid & id_halt & ~nop);
    cnt_d    = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  dff #(.W(SLOT_W)) u_x   (.clk(clk), .rst_n(rst), .d(x_d),      .q(x_q));
  dff #(.W(SLOT_W)) u_m   (.clk(clk), .rst_n(rst), .d(x_q),      .q(m_q));
  dff #(.W(1))      u_hlt (.clk(clk), .rst_n(rst), .d(halted_d), .q(halted_q));
  dff #(.W(CNT_W))  u_cnt (.clk(clk), .rst_n(rst), .d(cnt_d),    .q(cnt_q));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: one instance with writeback bypass and a
// 16-bit counter, one without bypass and a 4-bit counter, driven in lockstep.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_reg_write, id_halt, ex_redirect;
  logic [2:0] id_rs, id_rt, id_write_reg;

  logic        stall1, nop1, flush1, halted1;
  logic [15:0] cnt1;
  logic        stall0, nop0, flush0, halted0;
  logic [3:0]  cnt0;

  hazard_scoreboard #(.WB_BYPASS(1'b1), .CNT_W(16)) dut_byp (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_used(id_rs_used), .id_rs(id_rs),
    .id_rt_used(id_rt_used), .id_rt(id_rt), .id_reg_write(id_reg_write),
    .id_write_reg(id_write_reg), .id_halt(id_halt), .ex_redirect(ex_redirect),
    .stall(stall1), .nop(nop1), .flush_fd(flush1), .halted(halted1), .stall_count(cnt1)
  );

  hazard_scoreboard #(.WB_BYPASS(1'b0), .CNT_W(4)) dut_nobyp (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_used(id_rs_used), .id_rs(id_rs),
    .id_rt_used(id_rt_used), .id_rt(id_rt), .id_reg_write(id_reg_write),
    .id_write_reg(id_write_reg), .id_halt(id_halt), .ex_redirect(ex_redirect),
    .stall(stall0), .nop(nop0), .flush_fd(flush0), .halted(halted0), .stall_count(cnt0)
  );

  int nchk  = 0;
  int nfail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    int v, rsu, rs, rtu, rt, rw, wr, h, rd;
    int s1, n1, s0, n0, f, hl, c1, c0;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int v, int rsu, int rs, int rtu, int rt, int rw, int wr,
                              int h, int rd, int s1, int n1, int s0, int n0, int f,
                              int hl, int c1, int c0);
    vec_t t;
    t.v = v; t.rsu = rsu; t.rs = rs; t.rtu = rtu; t.rt = rt; t.rw = rw; t.wr = wr;
    t.h = h; t.rd = rd; t.s1 = s1; t.n1 = n1; t.s0 = s0; t.n0 = n0; t.f = f;
    t.hl = hl; t.c1 = c1; t.c0 = c0;
    return t;
  endfunction

  task automatic drive(input int v, input int rsu, input int rs, input int rtu, input int rt,
                       input int rw, input int wr, input int h, input int rd);
    id_valid     = (v != 0);
    id_rs_used   = (rsu != 0);
    id_rs        = 3'(rs);
    id_rt_used   = (rtu != 0);
    id_rt        = 3'(rt);
    id_reg_write = (rw != 0);
    id_write_reg = 3'(wr);
    id_halt      = (h != 0);
    ex_redirect  = (rd != 0);
  endtask

  // ---------------- behavioural reference model ----------------
  // Each instance keeps a list of destination registers still in flight
  // (youngest first, -1 = bubble), a halted flag and a stall tally.
  int pipe[2][3];
  bit hq[2];
  int cm[2];
  int cmax[2];
  bit byp[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) pipe[k][j] = -1;
      hq[k] = 1'b0;
      cm[k] = 0;
    end
  endtask

  task automatic model_out(input int k, output bit s, output bit n);
    bit haz;
    int depth;
    haz   = 1'b0;
    depth = byp[k] ? 2 : 3;
    for (int j = 0; j < depth; j++) begin
      if (pipe[k][j] >= 0 &&
          ((id_rs_used && int'(id_rs) == pipe[k][j]) ||
           (id_rt_used && int'(id_rt) == pipe[k][j])))
        haz = 1'b1;
    end
    haz = haz && id_valid;
    s = (haz || hq[k]) && !ex_redirect;
    n = s || ex_redirect || hq[k];
  endtask

  task automatic model_step();
    bit s, n, issue;
    for (int k = 0; k < 2; k++) begin
      model_out(k, s, n);
      issue = id_valid && !n;
      pipe[k][2] = pipe[k][1];
      pipe[k][1] = pipe[k][0];
      pipe[k][0] = (issue && id_reg_write) ? int'(id_write_reg) : -1;
      if (issue && id_halt) hq[k] = 1'b1;
      if (s && cm[k] < cmax[k]) cm[k]++;
    end
  endtask

  task automatic check_model(input int cyc);
    bit s, n;
    model_out(0, s, n);
    chk($sformatf("rnd%0d stall byp", cyc), int'(stall1), int'(s));
    chk($sformatf("rnd%0d nop byp", cyc), int'(nop1), int'(n));
    chk($sformatf("rnd%0d flush byp", cyc), int'(flush1), int'(ex_redirect));
    chk($sformatf("rnd%0d halted byp", cyc), int'(halted1), int'(hq[0]));
    chk($sformatf("rnd%0d count byp", cyc), int'(cnt1), cm[0]);
    model_out(1, s, n);
    chk($sformatf("rnd%0d stall nobyp", cyc), int'(stall0), int'(s));
    chk($sformatf("rnd%0d nop nobyp", cyc), int'(nop0), int'(n));
    chk($sformatf("rnd%0d flush nobyp", cyc), int'(flush0), int'(ex_redirect));
    chk($sformatf("rnd%0d halted nobyp", cyc), int'(halted0), int'(hq[1]));
    chk($sformatf("rnd%0d count nobyp", cyc), int'(cnt0), cm[1]);
  endtask

  initial begin
    cmax[0] = 65535; cmax[1] = 15;
    byp[0]  = 1'b1;  byp[1]  = 1'b0;

    // Hand-derived sequence: RAW stall (2 vs 3 cycles), redirect squash,
    // independent ops, self-dependency, WAW, unused operands, halt + saturation.
    tbl.push_back(mk(1,0,0,0,0,1,3,0,0, 0,0,0,0,0,0, 0,0));
    tbl.push_back(mk(1,1,3,0,0,1,5,0,0, 1,1,1,1,0,0, 0,0));
    tbl.push_back(mk(1,1,3,0,0,1,5,0,0, 1,1,1,1,0,0, 1,1));
    tbl.push_back(mk(1,1,3,0,0,1,5,0,0, 0,0,1,1,0,0, 2,2));
    tbl.push_back(mk(1,1,3,0,0,1,5,0,0, 0,0,0,0,0,0, 2,3));
    tbl.push_back(mk(1,1,5,0,0,1,6,0,1, 0,1,0,1,1,0, 2,3));
    tbl.push_back(mk(1,1,6,1,7,1,1,0,0, 0,0,0,0,0,0, 2,3));
    tbl.push_back(mk(1,1,2,1,4,0,0,0,0, 0,0,0,0,0,0, 2,3));
    tbl.push_back(mk(1,1,4,1,2,1,2,0,0, 0,0,0,0,0,0, 2,3));
    tbl.push_back(mk(1,1,7,0,0,1,7,0,0, 0,0,0,0,0,0, 2,3));
    tbl.push_back(mk(1,0,0,0,0,1,2,0,0, 0,0,0,0,0,0, 2,3));
    tbl.push_back(mk(1,0,2,0,7,0,0,0,0, 0,0,0,0,0,0, 2,3));
    tbl.push_back(mk(0,1,2,0,0,0,0,0,0, 0,0,0,0,0,0, 2,3));
    tbl.push_back(mk(1,0,0,1,2,0,0,0,0, 0,0,1,1,0,0, 2,3));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,0, 0,0,0,0,0,0, 2,4));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,1,1,0,1, 2+i,4+i));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1, 0,1,0,1,1,1, 12,14));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,1,1,0,1, 12,14));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,1,1,0,1, 13,15));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 1,1,1,1,0,1, 14,15));

    // Reset state
    rst = 1'b0;
    drive(0,0,0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall byp", int'(stall1), 0);
    chk("reset nop byp", int'(nop1), 0);
    chk("reset flush byp", int'(flush1), 0);
    chk("reset halted byp", int'(halted1), 0);
    chk("reset count byp", int'(cnt1), 0);
    chk("reset stall nobyp", int'(stall0), 0);
    chk("reset halted nobyp", int'(halted0), 0);
    chk("reset count nobyp", int'(cnt0), 0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].rsu, tbl[i].rs, tbl[i].rtu, tbl[i].rt,
            tbl[i].rw, tbl[i].wr, tbl[i].h, tbl[i].rd);
      #3;
      chk($sformatf("vec%0d stall byp", i), int'(stall1), tbl[i].s1);
      chk($sformatf("vec%0d nop byp", i), int'(nop1), tbl[i].n1);
      chk($sformatf("vec%0d stall nobyp", i), int'(stall0), tbl[i].s0);
      chk($sformatf("vec%0d nop nobyp", i), int'(nop0), tbl[i].n0);
      chk($sformatf("vec%0d flush byp", i), int'(flush1), tbl[i].f);
      chk($sformatf("vec%0d flush nobyp", i), int'(flush0), tbl[i].f);
      chk($sformatf("vec%0d halted byp", i), int'(halted1), tbl[i].hl);
      chk($sformatf("vec%0d halted nobyp", i), int'(halted0), tbl[i].hl);
      chk($sformatf("vec%0d count byp", i), int'(cnt1), tbl[i].c1);
      chk($sformatf("vec%0d count nobyp", i), int'(cnt0), tbl[i].c0);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a RAW stall
    rst = 1'b0;
    drive(0,0,0,0,0,0,0,0,0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1,0,0,0,0,1,3,0,0);
    @(posedge clk);
    #1;
    drive(1,1,3,0,0,0,0,0,0);
    #2;
    chk("mid stall byp", int'(stall1), 1);
    chk("mid stall nobyp", int'(stall0), 1);
    @(posedge clk);
    #1;
    chk("mid stall2 byp", int'(stall1), 1);
    chk("mid count byp", int'(cnt1), 1);
    #3;
    rst = 1'b0;
    #1;
    chk("async rst stall byp", int'(stall1), 0);
    chk("async rst stall nobyp", int'(stall0), 0);
    chk("async rst nop byp", int'(nop1), 0);
    chk("async rst count byp", int'(cnt1), 0);
    chk("async rst count nobyp", int'(cnt0), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("post rst slots byp", int'(stall1), 0);
    chk("post rst slots nobyp", int'(stall0), 0);
    chk("post rst count byp", int'(cnt1), 0);
    @(posedge clk);
    #1;

    // Randomised run against the reference model
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit in_rst;
      in_rst = (cyc % 400 == 399);
      rst = in_rst ? 1'b0 : 1'b1;
      if (in_rst) model_reset();
      drive(($urandom % 8) != 0, $urandom % 2, $urandom % 4, $urandom % 2, $urandom % 4,
            ($urandom % 4) != 0, $urandom % 4, ($urandom % 150) == 0, ($urandom % 10) == 0);
      #3;
      check_model(cyc);
      if (!in_rst) model_step();
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
